// File: rtl/control_sequencer.sv
// Hardwired fetch/execute step sequencer for the Datapath: walks T0-T6 and
// Moore-decodes every control strobe from the current step and the latched IR.
module control_sequencer #(
    parameter logic [4:0] OP_MUL     = 5'b01111,
    parameter logic [4:0] OP_DIV     = 5'b10000,
    parameter logic [4:0] OP_ALU_MAX = 5'b01100,
    parameter logic [4:0] OP_NOP     = 5'b01101
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  opcode,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;
    logic [3:0] rc_q, rc_d;

    logic is_alu_q;
    logic ir_is_alu;
    logic ir_is_muldiv;

    assign is_alu_q     = (op_q <= OP_ALU_MAX);
    assign ir_is_alu    = (ir[31:27] <= OP_ALU_MAX);
    assign ir_is_muldiv = (ir[31:27] == OP_MUL) || (ir[31:27] == OP_DIV);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            op_q    <= 5'd0;
            ra_q    <= 4'd0;
            rb_q    <= 4'd0;
            rc_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rout     = 16'd0;
        Rin      = 16'd0;
        opcode   = OP_NOP;
        done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                // The register fields are captured here so later ir changes cannot disturb execute.
                MDRout = 1'b1;
                IRin   = 1'b1;
                op_d   = ir[31:27];
                ra_d   = ir[26:23];
                rb_d   = ir[22:19];
                rc_d   = ir[18:15];
                if (ir_is_alu || ir_is_muldiv) begin
                    state_d = S_T3;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T3: begin
                Yin     = 1'b1;
                Rout    = 16'd1 << (is_alu_q ? rb_q : ra_q);
                state_d = S_T4;
            end
            S_T4: begin
                Zin     = 1'b1;
                opcode  = op_q;
                Rout    = 16'd1 << (is_alu_q ? rc_q : rb_q);
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_alu_q) begin
                    Rin     = 16'd1 << ra_q;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a table of instructions run through a
// small Datapath model, plus hand-written reset, back-to-back and mid-instruction clear cases.
module tb_control_sequencer;

    localparam logic [4:0] OP_NOP = 5'b01101;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic        Zlowout, Zhighout, HIin, LOin, done;
    logic [15:0] Rout, Rin;
    logic [4:0]  opcode;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Rout(Rout), .Rin(Rin), .opcode(opcode), .done(done)
    );

    always #5 clock = ~clock;

    logic [14:0] strobes;
    assign strobes = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin,
                      Yin, Zlowout, Zhighout, HIin, LOin, done};

    // Datapath model: bus, Y, Z, HI/LO, PC, MDR and a 16-entry register file.
    logic        tb_load;
    logic [31:0] regs [16];
    logic [31:0] y_r, pc_r, mdr_r, lo_r, hi_r, bus;
    logic [63:0] z_r;

    always_comb begin
        bus = 32'd0;
        if (PCout)         bus = pc_r;
        else if (MDRout)   bus = mdr_r;
        else if (Zlowout)  bus = z_r[31:0];
        else if (Zhighout) bus = z_r[63:32];
        else begin
            for (int i = 0; i < 16; i++)
                if (Rout[i]) bus = regs[i];
        end
    end

    always @(posedge clock) begin
        if (tb_load) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
            regs[1] <= 32'd5;
            regs[2] <= 32'd7;
            regs[4] <= 32'd9;
            regs[5] <= 32'd2;
            y_r <= 0; z_r <= 0; pc_r <= 0; mdr_r <= 0; lo_r <= 0; hi_r <= 0;
        end else begin
            if (Yin) y_r <= bus;
            if (Zin) begin
                if (IncPC)                 z_r <= {32'd0, bus + 32'd1};
                else if (opcode == 5'b01111) z_r <= {32'd0, y_r} * {32'd0, bus};
                else if (opcode == 5'b10000) z_r <= (bus == 0) ? 64'd0 : {y_r % bus, y_r / bus};
                else                       z_r <= {32'd0, y_r + bus};
            end
            if (LOin) lo_r <= bus;
            if (HIin) hi_r <= bus;
            if (PCin) pc_r <= bus;
            if (Read && MDRin) mdr_r <= 32'hA5000000 | pc_r;
            for (int i = 0; i < 16; i++)
                if (Rin[i]) regs[i] <= bus;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          wait_cyc;
        int          exp_cycles;
        logic [15:0] exp_t3;
        logic [15:0] exp_t4;
        logic [4:0]  exp_op;
        logic [15:0] exp_rin;
        int          exp_lo_p;
        int          exp_hi_p;
        int          kind;      // 0 none, 1 check LO/HI, 2 check regs[exp_b]
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t tbl [6];

    task automatic exec(input vec_t v);
        int cyc, t1, lo_p, hi_p, zh_cnt, zh_bad, bus_bad, op_bad;
        logic [15:0] t3r, t4r, rin;
        logic [4:0]  t4op;
        logic        got_done;
        cyc = 0; t1 = 0; lo_p = 0; hi_p = 0; zh_cnt = 0; zh_bad = 0; bus_bad = 0; op_bad = 0;
        t3r = 0; t4r = 0; rin = 0; t4op = OP_NOP; got_done = 0;
        ir = v.ir; mem_ready = 1'b0; run = 1'b1;
        while (!got_done && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                run = 1'b0;
                if (!PCout) bus_bad++;
            end
            if ((PCout + MDRout + Zlowout + Zhighout + (Rout != 0)) > 1) bus_bad++;
            if ($countones(Rout) > 1) bus_bad++;
            if (Yin && Rout != 0) t3r = Rout;
            if (Zin && Rout != 0) begin t4r = Rout; t4op = opcode; end
            else if (opcode != OP_NOP) op_bad++;
            if (Rin != 0) rin = Rin;
            if (LOin) lo_p++;
            if (HIin) hi_p++;
            if (Zhighout) begin zh_cnt++; if (!done) zh_bad++; end
            if (Read) begin t1++; mem_ready = (t1 >= v.wait_cyc + 1); end
            if (done) got_done = 1'b1;
        end
        chk({v.name, " done_seen"}, 64'(got_done), 64'd1);
        chk({v.name, " cycles"}, 64'(cyc), 64'(v.exp_cycles));
        chk({v.name, " t1_cycles"}, 64'(t1), 64'(v.wait_cyc + 1));
        chk({v.name, " t3_rout"}, 64'(t3r), 64'(v.exp_t3));
        chk({v.name, " t4_rout"}, 64'(t4r), 64'(v.exp_t4));
        chk({v.name, " t4_opcode"}, 64'(t4op), 64'(v.exp_op));
        chk({v.name, " rin"}, 64'(rin), 64'(v.exp_rin));
        chk({v.name, " lo_pulses"}, 64'(lo_p), 64'(v.exp_lo_p));
        chk({v.name, " hi_pulses"}, 64'(hi_p), 64'(v.exp_hi_p));
        chk({v.name, " zhigh_cycles"}, 64'(zh_cnt), 64'(v.exp_hi_p));
        chk({v.name, " zhigh_outside_t6"}, 64'(zh_bad), 64'd0);
        chk({v.name, " bus_conflicts"}, 64'(bus_bad), 64'd0);
        chk({v.name, " opcode_not_nop"}, 64'(op_bad), 64'd0);
        @(negedge clock);
        chk({v.name, " idle_strobes"}, {34'd0, strobes, Rout != 0, Rin != 0, opcode}, {49'd0, OP_NOP});
        if (v.kind == 1) begin
            chk({v.name, " model_lo"}, 64'(lo_r), 64'(v.exp_a));
            chk({v.name, " model_hi"}, 64'(hi_r), 64'(v.exp_b));
        end else if (v.kind == 2) begin
            chk({v.name, " model_reg"}, 64'(regs[v.exp_b[3:0]]), 64'(v.exp_a));
        end
        $display("instr %s ir=0x%08h cycles=%0d t3=0x%04h t4=0x%04h op=%b rin=0x%04h lo=%0d hi=%0d",
                 v.name, v.ir, cyc, t3r, t4r, t4op, rin, lo_r, hi_r);
    endtask

    initial begin
        logic [31:0] lo_before, hi_before;
        int          n, pulses;
        logic        seen;

        tbl[0] = '{"div_r4_r5",  32'h82280000, 0,  7, 16'h0010, 16'h0020, 5'b10000, 16'h0000, 1, 1, 1, 32'd4,  32'd1};
        tbl[1] = '{"mul_r4_r5",  32'h7A280000, 0,  7, 16'h0010, 16'h0020, 5'b01111, 16'h0000, 1, 1, 1, 32'd18, 32'd0};
        tbl[2] = '{"add_r3",     32'h19908000, 0,  6, 16'h0004, 16'h0002, 5'b00011, 16'h0008, 0, 0, 2, 32'd12, 32'd3};
        tbl[3] = '{"div_wait4",  32'h82280000, 4, 11, 16'h0010, 16'h0020, 5'b10000, 16'h0000, 1, 1, 1, 32'd4,  32'd1};
        tbl[4] = '{"nop_fetch",  32'h68000000, 0,  3, 16'h0000, 16'h0000, OP_NOP,   16'h0000, 0, 0, 0, 32'd0,  32'd0};
        tbl[5] = '{"alu_r0",     32'h00090000, 1,  7, 16'h0002, 16'h0004, 5'b00000, 16'h0001, 0, 0, 2, 32'd12, 32'd0};

        // Reset held three cycles, then released with run low.
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'd0; tb_load = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("reset_strobes", {strobes, Rout, Rin}, 47'd0);
            chk("reset_opcode", 64'(opcode), 64'(OP_NOP));
        end
        tb_load = 1'b0;
        clear = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("idle_run0_strobes", {strobes, Rout, Rin}, 47'd0);
            chk("idle_run0_opcode", 64'(opcode), 64'(OP_NOP));
        end
        $display("reset: outputs idle, opcode=%b", opcode);

        for (int i = 0; i < 6; i++) exec(tbl[i]);

        // Back-to-back: run held through done gives one IDLE cycle then T0.
        ir = 32'h68000000; mem_ready = 1'b1; run = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clock); n++;
            if (done) seen = 1'b1;
        end
        chk("b2b_first_done", 64'(seen), 64'd1);
        @(negedge clock);
        chk("b2b_idle_gap", 64'(strobes), 64'd0);
        @(negedge clock);
        chk("b2b_second_t0", 64'(PCout && MARin && IncPC && Zin), 64'd1);
        run = 1'b0;
        repeat (3) @(negedge clock);
        chk("b2b_back_idle", 64'(strobes), 64'd0);
        $display("back_to_back: second fetch started after one idle cycle");

        // Clear asserted in T4 of a DIV aborts with no HI/LO load.
        lo_before = lo_r; hi_before = hi_r;
        ir = 32'h82280000; mem_ready = 1'b1; run = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clock); n++;
            if (n == 1) run = 1'b0;
            if (Zin && Rout != 0) seen = 1'b1;
        end
        chk("abort_reached_t4", 64'(seen), 64'd1);
        clear = 1'b0;
        #1;
        chk("abort_strobes_now", {strobes, Rout, Rin}, 47'd0);
        chk("abort_opcode_now", 64'(opcode), 64'(OP_NOP));
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (HIin || LOin || done) pulses++;
        end
        clear = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (HIin || LOin || done || PCout) pulses++;
        end
        chk("abort_no_pulses", 64'(pulses), 64'd0);
        chk("abort_lo_kept", 64'(lo_r), 64'(lo_before));
        chk("abort_hi_kept", 64'(hi_r), 64'(hi_before));
        $display("clear_mid_div: aborted in T4, lo=%0d hi=%0d", lo_r, hi_r);
        exec(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
